// File: rtl/serial_result_register_86_if.sv
// serial_result_register_86_if: adder-side serial streams and host load/snapshot handshake
interface serial_result_register_86_if #(parameter int DIGITS = 14) ();
  localparam int W = 4 * DIGITS;
  logic         sum1;
  logic         sum2;
  logic         use_sum2;
  logic         ws;
  logic         first_bit;
  logic         t1;
  logic         t2;
  logic         t3;
  logic         t4;
  logic         load_req;
  logic [W-1:0] load_data;
  logic         snap_req;
  logic         ser_out;
  logic [W-1:0] word_out;
  logic         load_ack;
  logic         snap_ack;
  modport master (
    output sum1, sum2, use_sum2, ws, first_bit, t1, t2, t3, t4, load_req, load_data, snap_req,
    input  ser_out, word_out, load_ack, snap_ack
  );
  modport slave (
    input  sum1, sum2, use_sum2, ws, first_bit, t1, t2, t3, t4, load_req, load_data, snap_req,
    output ser_out, word_out, load_ack, snap_ack
  );
endinterface

// File: rtl/serial_result_register_86.sv
// serial_result_register_86: circulating bit-serial result register with BCD correction and word-aligned load/snapshot
module serial_result_register_86 #(parameter int DIGITS = 14) (
  input logic clk,
  input logic rst,
  serial_result_register_86_if.slave sr_if
);
  localparam int W = 4 * DIGITS;
  logic [3:0]   h_q, h_d, k_q, k_d;
  logic [W-5:0] l_q, l_d;
  logic [W-1:0] word_q, word_d;
  logic         load_pend_q, load_pend_d, snap_pend_q, snap_pend_d;
  logic         load_word_q, load_word_d, load_ack_q, snap_ack_q;
  logic         svc_load, svc_snap, wr_en, corr, d;
  always_comb begin
    svc_load    = sr_if.first_bit & (load_pend_q | sr_if.load_req);
    svc_snap    = sr_if.first_bit & (snap_pend_q | sr_if.snap_req);
    wr_en       = sr_if.ws & ~load_word_q;
    corr        = sr_if.t4 & ~(sr_if.t1 | sr_if.t2 | sr_if.t3) & sr_if.use_sum2 & wr_en;
    d           = wr_en ? sr_if.sum1 : l_q[0];
    k_d         = {sr_if.sum2, k_q[3:1]};
    // a correction replaces the whole digit just assembled in the holding nibble
    {h_d, l_d}  = svc_load ? {sr_if.load_data[0], sr_if.load_data[W-1:1]}
                           : {(corr ? k_d : {d, h_q[3:1]}), h_q[0], l_q[W-5:1]};
    word_d      = svc_snap ? {h_q, l_q} : word_q;
    load_pend_d = ~sr_if.first_bit & (load_pend_q | sr_if.load_req);
    snap_pend_d = ~sr_if.first_bit & (snap_pend_q | sr_if.snap_req);
    load_word_d = svc_load | (load_word_q & ~sr_if.first_bit);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_q         <= '0;
      l_q         <= '0;
      k_q         <= '0;
      word_q      <= '0;
      load_pend_q <= 1'b0;
      snap_pend_q <= 1'b0;
      load_word_q <= 1'b0;
      load_ack_q  <= 1'b0;
      snap_ack_q  <= 1'b0;
    end else begin
      h_q         <= h_d;
      l_q         <= l_d;
      k_q         <= k_d;
      word_q      <= word_d;
      load_pend_q <= load_pend_d;
      snap_pend_q <= snap_pend_d;
      load_word_q <= load_word_d;
      load_ack_q  <= svc_load;
      snap_ack_q  <= svc_snap;
    end
  assign sr_if.ser_out  = svc_load ? sr_if.load_data[0] : l_q[0];
  assign sr_if.word_out = word_q;
  assign sr_if.load_ack = load_ack_q;
  assign sr_if.snap_ack = snap_ack_q;
endmodule

// File: tb/tb_serial_result_register_86.sv
// tb_serial_result_register_86: random + directed stimulus, word-level reference model, queued scoreboard
module tb_serial_result_register_86;
  localparam int W = 56;
  typedef struct { logic ser; logic lack; logic sack; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  serial_result_register_86_if sr();
  serial_result_register_86 dut (.clk(clk), .rst(rst), .sr_if(sr));
  exp_t         exp_q[$];
  logic [W-1:0] word_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] m_cur, m_base, m_nxt, ld_data;
  logic         m_lpend, m_spend, m_loaded, m_prev_loaded, m_lack, m_sack;
  logic [3:0]   m_s2;
  logic         lreq_g, sreq_g;
  int           pcnt;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic model_clear();
    m_cur = '0; m_base = '0; m_nxt = '0; m_s2 = '0;
    m_lpend = 0; m_spend = 0; m_loaded = 0; m_prev_loaded = 0; m_lack = 0; m_sack = 0;
    lreq_g = 0; sreq_g = 0; pcnt = 0;
  endtask
  task automatic drive_idle();
    sr.ws = 0; sr.sum1 = 0; sr.sum2 = 0; sr.use_sum2 = 0; sr.first_bit = 0;
    sr.t1 = 0; sr.t2 = 0; sr.t3 = 0; sr.t4 = 0; sr.load_req = 0; sr.snap_req = 0;
  endtask
  // one bit time: drive inputs, advance the word-level model, queue the expected outputs
  task automatic step(input logic ws, input logic s1, input logic s2, input logic use2);
    logic svl, svs;
    @(posedge clk); #1;
    svl = 0; svs = 0;
    sr.ws = ws; sr.sum1 = s1; sr.sum2 = s2; sr.use_sum2 = use2;
    sr.first_bit = (pcnt == 0);
    sr.t1 = (pcnt % 4 == 0); sr.t2 = (pcnt % 4 == 1); sr.t3 = (pcnt % 4 == 2); sr.t4 = (pcnt % 4 == 3);
    sr.load_req = lreq_g; sr.snap_req = sreq_g; sr.load_data = ld_data;
    if (pcnt == 0) begin
      svl = m_lpend | lreq_g;
      svs = m_spend | sreq_g;
      if (svs) word_q.push_back(m_cur);
      m_prev_loaded = m_loaded;
      m_loaded = svl;
      m_base = svl ? ld_data : m_cur;
      m_nxt = m_base;
      m_lpend = 0; m_spend = 0;
    end else begin
      m_lpend |= lreq_g;
      m_spend |= sreq_g;
    end
    exp_q.push_back('{m_base[pcnt], m_lack, m_sack});
    m_lack = svl; m_sack = svs;
    if (!m_loaded && ws && !(pcnt == 0 && m_prev_loaded)) m_nxt[pcnt] = s1;
    m_s2[pcnt % 4] = s2;
    if (pcnt % 4 == 3 && use2 && ws && !m_loaded) m_nxt[pcnt-3 +: 4] = m_s2;
    if (pcnt == W - 1) m_cur = m_nxt;
    if (svl) lreq_g = 0;
    if (svs) sreq_g = 0;
    pcnt = (pcnt + 1) % W;
  endtask
  task automatic run(input int n, input logic ws);
    repeat (n) step(ws, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic run_rand(input int n);
    repeat (n) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic align(input int p);
    while (pcnt != p) run(1, 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_ser_out"}, W'(sr.ser_out), '0);
    chk({tag, "_word_out"}, sr.word_out, '0);
    chk({tag, "_load_ack"}, W'(sr.load_ack), '0);
    chk({tag, "_snap_ack"}, W'(sr.snap_ack), '0);
  endtask
  task automatic do_reset(input string tag);
    #2 rst = 1;
    drive_idle();
    exp_q.delete();
    word_q.delete();
    #1 reset_checks(tag);
    repeat (3) @(posedge clk);
    #1 reset_checks({tag, "_hold"});
    #1 rst = 0;
    model_clear();
  endtask
  always @(negedge clk)
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ser_out", W'(sr.ser_out), W'(mon_e.ser));
      chk("load_ack", W'(sr.load_ack), W'(mon_e.lack));
      chk("snap_ack", W'(sr.snap_ack), W'(mon_e.sack));
      if (sr.snap_ack) begin
        if (word_q.size() > 0) chk("word_out", sr.word_out, word_q.pop_front());
        else begin
          total++;
          bad++;
          $display("FAIL word_out: snap_ack with no snapshot expected, act=%h", sr.word_out);
        end
      end
    end
  initial begin
    drive_idle();
    sr.load_data = '0;
    ld_data = '0;
    model_clear();
    #2 rst = 1;
    #2 reset_checks("por");
    repeat (2) @(posedge clk);
    #2 rst = 0;
    run(W, 0);
    // load 0x123 requested mid-word, then snapshot it
    run(10, 0);
    ld_data = 56'h123; lreq_g = 1;
    run(2 * W, 0);
    sreq_g = 1;
    run(W + 5, 0);
    // recirculation is stable over several words
    ld_data = 56'h98765432109876; lreq_g = 1;
    run(W, 0);
    for (int i = 0; i < 3; i++) begin
      sreq_g = 1;
      run(W, 0);
    end
    // digit 0 written with a plain sum of 7
    align(0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    run(W - 4, 0);
    sreq_g = 1;
    run(W, 0);
    // digit 0 written with raw 12, corrected to 2
    align(0);
    step(1, 0, 0, 1); step(1, 0, 1, 0); step(1, 1, 0, 0); step(1, 1, 0, 1);
    run(W - 4, 0);
    sreq_g = 1;
    run(W, 0);
    // simultaneous load and snapshot while the adder is writing
    align(20);
    ld_data = 56'h0A5A5A5A5A5A5A; lreq_g = 1; sreq_g = 1;
    run(2 * W, 1);
    sreq_g = 1;
    run(W, 0);
    // random traffic with random request timing
    for (int i = 0; i < 12 * W; i++) begin
      if (!lreq_g && $urandom_range(0, 60) == 0) begin
        ld_data = W'({$urandom(), $urandom()});
        lreq_g = 1;
      end
      if (!sreq_g && $urandom_range(0, 30) == 0) sreq_g = 1;
      run_rand(1);
    end
    align(0);
    // all-nines word, then reset in the middle of a word
    ld_data = 56'h99999999999999; lreq_g = 1;
    run(W, 0);
    sreq_g = 1;
    run(W + 17, 0);
    do_reset("mid");
    run(W, 0);
    run(2, 0);
    chk("word_q_empty", W'(word_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_result_register_86.md
# serial_result_register_86

Receiving end of the serial adder path: a 56-bit circulating bit-serial register whose top nibble is the decimal holding register. It accepts the adder's raw sum (SUM1) and corrected sum (SUM2) streams and commits the corrected digit at T4 when the adder asserts USE_SUM2. Its serial output returns the operand stream to the adder's X_IN. A word-aligned load/snapshot handshake gives parallel access for host or display logic.

## Interface
- Digits, 14, number of BCD digits per word; word width W = 4*Digits bits.
- PHI2  in  1  bit-rate clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SUM1  in  1  raw serial sum or difference bit from the adder.
- SUM2  in  1  corrected serial sum bit from the adder.
- USE_SUM2  in  1  valid only in T4; selects the corrected digit.
- WS  in  1  word select; 1 = write the adder result, 0 = recirculate.
- FIRST_BIT  in  1  marks bit 0 of digit 0; coincides with T1.
- T1, T2, T3, T4  in  1 each  one-hot bit-in-digit state; T1 is the LSbit.
- LOAD_REQ  in  1  level request to load LOAD_DATA.
- LOAD_DATA  in  W  parallel word; bit 0 = LSbit of digit 0. Must be held until LOAD_ACK.
- SNAP_REQ  in  1  level request to capture the current word.
- SER_OUT  out  1  serial operand bit to the adder X_IN.
- WORD_OUT  out  W  last captured word.
- LOAD_ACK  out  1  one-cycle pulse when the load is performed.
- SNAP_ACK  out  1  one-cycle pulse when WORD_OUT is updated.

## Operation
- State: H[3:0] (holding nibble); L[W-5:0] (low part); K[3:0] (correction shifter); load_pend, snap_pend, load_word. Loop order {H,L}; L[0] is the oldest bit.
- Input bit d = (WS & ~load_word) ? SUM1 : L[0].
- Each edge:
  - L <= {H[0], L[W-5:1]}.
  - K <= {SUM2, K[3:1]}.
  - H <= {d, H[3:1]}, except when T4 & USE_SUM2 & WS & ~load_word: H <= {SUM2, K[3:1]}, which replaces the whole digit with the corrected value.
- After the T4 edge, H holds the just-completed digit; the previous digit's MSbit has moved into L.
- SER_OUT = svc_load ? LOAD_DATA[0] : L[0].
- Service signals (combinational):
  - svc_load = FIRST_BIT & (load_pend | LOAD_REQ).
  - svc_snap = FIRST_BIT & (snap_pend | SNAP_REQ).
- Pending flags: set on REQ when FIRST_BIT is low; cleared when serviced.
- svc_snap edge: WORD_OUT <= {H,L} (the pre-load contents); SNAP_ACK = 1 for the next cycle.
- svc_load edge:
  - {H,L} <= {LOAD_DATA[0], LOAD_DATA[W-1:1]}, i.e. the state after one shift.
  - load_word <= 1; LOAD_ACK = 1 for the next cycle.
  - load_word stays 1 until the next FIRST_BIT edge without svc_load, so adder writes are suppressed for the entire loaded word.
- A request asserted in the FIRST_BIT cycle is serviced in that same cycle.
- A REQ still high after its ACK is a new request.

## Timing
- Reset values: H, L, K, WORD_OUT = 0; LOAD_ACK, SNAP_ACK = 0; pend flags and load_word = 0; SER_OUT = 0 (unless svc_load).
- Reset asserted mid-word clears everything immediately; any pending request is dropped.
- The loop is exactly W cycles: with WS = 0, the word returns unchanged every W cycles.
- Write latency: a digit's sum is visible in the next snapshot after its word.
- Load latency: 1 to W cycles from REQ to ACK; the first loaded bit appears on SER_OUT in the FIRST_BIT cycle.
- Snapshot latency: 1 to W cycles. Simultaneous load and snapshot: snapshot is served first (old word); both ACKs pulse in the same cycle.
- USE_SUM2 outside T4 is ignored.
- WS is sampled per bit; WS toggling mid-digit is allowed (bitwise select). A correction requires WS at T4.

## Test plan
- Reset mid-word with H = 4'h9 → SER_OUT = 0, WORD_OUT = 0, no ACK; after release, W cycles of SER_OUT = 0.
- LOAD_DATA = 56'h123 → LOAD_ACK at FIRST_BIT+1; SER_OUT = 1,1,0,0,0,1,0,0,1,0,0,0,0…; the next snapshot returns 56'h123.
- WS = 0 for 3 words after loading 56'h98765432109876 → every snapshot is identical.
- WS = 1 during digit 0, SUM1 = 1,1,1,0 (7), USE_SUM2 = 0 → digit 0 = 7, other digits unchanged.
- WS = 1 during digit 0, SUM1 = 0,0,1,1 (12), SUM2 = 0,1,0,0, USE_SUM2 = 1 at T4 → digit 0 = 2.
- LOAD_REQ and SNAP_REQ raised together with WS = 1 → WORD_OUT = old word; the loaded word survives its first pass unmodified; both ACKs are coincident.
